// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-master boot ROM arbiter.
package rom_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } state_t;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    // Width of a counter that must hold values 0..t inclusive.
    function automatic int unsigned cnt_width(input int unsigned t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-request round-robin arbiter; remembers the last winner and favours the other on a tie.
module rr_arbiter_2
    import rom_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant_c,
    output logic       last_grant
);

    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = (last_grant == GRANT_M0) ? 2'b10 : 2'b01;
            default: grant_c = 2'b00;
        endcase
    end

    // Reset to m1 so that m0 wins the first contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_M1;
        end else if (update && (|req)) begin
            last_grant <= grant_c[1];
        end
    end

endmodule

// File: rtl/rom_bus_arbiter.sv
// Shares a single-port read-only boot ROM between the ifetch (m0) and data-load (m1)
// Wishbone classic masters; one access in flight, writes and ROM timeouts answered with err.
module rom_bus_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_adr,
    output logic [DATA_WIDTH-1:0] m0_dat,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_adr,
    output logic [DATA_WIDTH-1:0] m1_dat,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_stb,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  rom_ack
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    state_t                state;
    logic                  winner;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            req_c;
    logic [1:0]            grant_c;
    logic                  last_grant;
    logic                  update_c;
    logic                  win_c;
    logic                  sel_we_c;
    logic [ADDR_WIDTH-1:0] sel_adr_c;
    logic                  win_cyc_c;

    assign req_c     = {m1_cyc & m1_stb, m0_cyc & m0_stb};
    assign update_c  = (state == IDLE);
    assign win_c     = grant_c[1];
    assign sel_we_c  = grant_c[0] ? m0_we  : m1_we;
    assign sel_adr_c = grant_c[0] ? m0_adr : m1_adr;
    assign win_cyc_c = (winner == GRANT_M1) ? m1_cyc : m0_cyc;

    rr_arbiter_2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (req_c),
        .update     (update_c),
        .grant_c    (grant_c),
        .last_grant (last_grant)
    );

    // Access sequencer: ack/err/stb are single-cycle pulses cleared by default each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            winner   <= GRANT_M0;
            cnt      <= '0;
            rom_addr <= '0;
            rom_stb  <= 1'b0;
            m0_dat   <= '0;
            m1_dat   <= '0;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
        end else begin
            rom_stb <= 1'b0;
            m0_ack  <= 1'b0;
            m0_err  <= 1'b0;
            m1_ack  <= 1'b0;
            m1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_c) begin
                        winner <= win_c;
                        if (sel_we_c) begin
                            state <= ERR;
                            if (win_c == GRANT_M1) m1_err <= 1'b1;
                            else                   m0_err <= 1'b1;
                        end else begin
                            rom_addr <= sel_adr_c;
                            rom_stb  <= 1'b1;
                            cnt      <= '0;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // A master that abandoned its cycle gets neither ack nor err.
                    if (rom_ack) begin
                        if (win_cyc_c) begin
                            if (winner == GRANT_M1) begin
                                m1_dat <= rom_data;
                                m1_ack <= 1'b1;
                            end else begin
                                m0_dat <= rom_data;
                                m0_ack <= 1'b1;
                            end
                            state <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        if (win_cyc_c) begin
                            if (winner == GRANT_M1) m1_err <= 1'b1;
                            else                    m0_err <= 1'b1;
                            state <= ERR;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Directed bench for rom_bus_arbiter: table of single-shot transactions plus hand-written corner sequences.
module tb_rom_bus_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_adr = '0;
    logic [DW-1:0] m0_dat;
    logic          m0_ack, m0_err;
    logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_adr = '0;
    logic [DW-1:0] m1_dat;
    logic          m1_ack, m1_err;
    logic [AW-1:0] rom_addr;
    logic          rom_stb;
    logic [DW-1:0] rom_data;
    logic          rom_ack;

    logic          rom_en = 1'b1;
    logic          force_ack = 1'b0;
    logic          rom_ack_q = 1'b0;
    logic [DW-1:0] rom_data_q = '0;

    int total = 0;
    int bad   = 0;

    rom_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat(m0_dat), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat(m1_dat), .m1_ack(m1_ack), .m1_err(m1_err),
        .rom_addr(rom_addr), .rom_stb(rom_stb), .rom_data(rom_data), .rom_ack(rom_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == AW'(4)) return 32'hDEADBEEF;
        return 32'hA5A50000 | DW'(a);
    endfunction

    // Registered ROM: ack and data one cycle after stb.
    always @(posedge clk) begin
        rom_ack_q <= rom_stb & rom_en;
        if (rom_stb) rom_data_q <= rom_word(rom_addr);
    end
    assign rom_ack  = rom_ack_q | force_ack;
    assign rom_data = rom_data_q;

    typedef struct {
        logic          m0_req;
        logic          m0_we;
        logic [AW-1:0] m0_adr;
        logic          m1_req;
        logic          m1_we;
        logic [AW-1:0] m1_adr;
        logic          en;
        int            e_m0_ack;
        int            e_m0_err;
        int            e_m1_ack;
        int            e_m1_err;
        int            e_stb;
        int            e_stb_cnt;
        logic [AW-1:0] e_stb_adr;
        logic [DW-1:0] e_m0_dat;
        logic [DW-1:0] e_m1_dat;
    } vec_t;

    int            cyc = 0;
    int            m0_ack_at, m0_err_at, m1_ack_at, m1_err_at;
    int            stb_first, stb_cnt, overlap, n_done;
    logic [AW-1:0] stb_adr;
    logic          m0_hold = 1'b0, m1_hold = 1'b0;
    int            order[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkx(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        m0_ack_at = -1; m0_err_at = -1; m1_ack_at = -1; m1_err_at = -1;
        stb_first = -1; stb_cnt = 0; overlap = 0; n_done = 0; stb_adr = '0;
        order.delete();
    endtask

    // One clock: sample on the falling edge, log events, release masters that were answered.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (m0_ack && m0_ack_at < 0) m0_ack_at = cyc;
        if (m0_err && m0_err_at < 0) m0_err_at = cyc;
        if (m1_ack && m1_ack_at < 0) m1_ack_at = cyc;
        if (m1_err && m1_err_at < 0) m1_err_at = cyc;
        if (rom_stb) begin
            if (stb_first < 0) begin
                stb_first = cyc;
                stb_adr = rom_addr;
            end
            stb_cnt++;
        end
        if ((int'(m0_ack) + int'(m0_err) + int'(m1_ack) + int'(m1_err)) > 1) overlap++;
        if (m0_ack || m0_err) begin
            order.push_back(0);
            n_done++;
            if (!m0_hold) begin m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; end
        end
        if (m1_ack || m1_err) begin
            order.push_back(1);
            n_done++;
            if (!m1_hold) begin m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; end
        end
    endtask

    function automatic int rel(input int at, input int c0);
        return (at < 0) ? -1 : at - c0;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int c0;
        string p;
        p = $sformatf("v%0d", idx);
        clear_log();
        rom_en = v.en;
        m0_cyc = v.m0_req; m0_stb = v.m0_req; m0_we = v.m0_we; m0_adr = v.m0_adr;
        m1_cyc = v.m1_req; m1_stb = v.m1_req; m1_we = v.m1_we; m1_adr = v.m1_adr;
        c0 = cyc;
        for (int i = 0; i < 30; i++) step();
        chk({p, "_m0_ack_cyc"}, rel(m0_ack_at, c0), v.e_m0_ack);
        chk({p, "_m0_err_cyc"}, rel(m0_err_at, c0), v.e_m0_err);
        chk({p, "_m1_ack_cyc"}, rel(m1_ack_at, c0), v.e_m1_ack);
        chk({p, "_m1_err_cyc"}, rel(m1_err_at, c0), v.e_m1_err);
        chk({p, "_stb_cyc"}, rel(stb_first, c0), v.e_stb);
        chk({p, "_stb_cnt"}, stb_cnt, v.e_stb_cnt);
        if (v.e_stb >= 0) chkx({p, "_stb_adr"}, DW'(stb_adr), DW'(v.e_stb_adr));
        chkx({p, "_m0_dat"}, m0_dat, v.e_m0_dat);
        chkx({p, "_m1_dat"}, m1_dat, v.e_m1_dat);
        chk({p, "_overlap"}, overlap, 0);
        rom_en = 1'b1;
    endtask

    vec_t vecs[7];
    vec_t v;
    int   c0;

    initial begin
        // m0req we adr | m1req we adr | en | m0ack m0err m1ack m1err stb stbcnt stbadr | m0dat m1dat
        vecs[0] = '{1, 0, 15'h0010, 1, 0, 15'h0020, 1, 3, -1, 7, -1, 1, 2, 15'h0010, 32'hA5A50010, 32'hA5A50020};
        vecs[1] = '{1, 0, 15'h0004, 0, 0, 15'h0000, 1, 3, -1, -1, -1, 1, 1, 15'h0004, 32'hDEADBEEF, 32'hA5A50020};
        vecs[2] = '{0, 0, 15'h0000, 1, 1, 15'h0100, 1, -1, -1, -1, 1, -1, 0, 15'h0000, 32'hDEADBEEF, 32'hA5A50020};
        vecs[3] = '{1, 0, 15'h0008, 0, 0, 15'h0000, 0, -1, 18, -1, -1, 1, 1, 15'h0008, 32'hDEADBEEF, 32'hA5A50020};
        vecs[4] = '{1, 0, 15'h0030, 1, 0, 15'h0034, 1, 7, -1, 3, -1, 1, 2, 15'h0034, 32'hA5A50030, 32'hA5A50034};
        vecs[5] = '{1, 1, 15'h0040, 1, 0, 15'h0044, 1, -1, 5, 3, -1, 1, 1, 15'h0044, 32'hA5A50030, 32'hA5A50044};
        vecs[6] = '{0, 0, 15'h0000, 1, 0, 15'h0003, 1, -1, -1, 3, -1, 1, 1, 15'h0003, 32'hA5A50030, 32'hA5A50003};

        clear_log();
        repeat (3) @(negedge clk);
        chk("rst_rom_stb", int'(rom_stb), 0);
        chk("rst_acks", int'({m0_ack, m0_err, m1_ack, m1_err}), 0);
        chkx("rst_rom_addr", DW'(rom_addr), '0);
        chkx("rst_m0_dat", m0_dat, '0);
        chkx("rst_m1_dat", m1_dat, '0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Both masters hold requests: grants must alternate starting with m0.
        clear_log();
        m0_hold = 1'b1; m1_hold = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 15'h0040;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 15'h0080;
        for (int i = 0; i < 80 && n_done < 8; i++) begin
            step();
            if (n_done >= 8) begin
                m0_hold = 1'b0; m1_hold = 1'b0;
                m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
            end
        end
        m0_hold = 1'b0; m1_hold = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        chk("rr_done_cnt", n_done, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < order.size()) chk($sformatf("rr_grant%0d", i), order[i], i % 2);
        end
        chk("rr_overlap", overlap, 0);
        chk("rr_stb_cnt", stb_cnt, 8);
        chkx("rr_m0_dat", m0_dat, 32'hA5A50040);
        chkx("rr_m1_dat", m1_dat, 32'hA5A50080);
        repeat (3) step();

        // m0 abandons its cycle in WAIT: access completes silently.
        clear_log();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 15'h0050;
        step(); step();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        repeat (8) step();
        chk("drop_m0_ack", m0_ack_at, -1);
        chk("drop_m0_err", m0_err_at, -1);
        chk("drop_stb_cnt", stb_cnt, 1);
        chkx("drop_m0_dat", m0_dat, 32'hA5A50040);
        v = '{1, 0, 15'h0054, 0, 0, 15'h0000, 1, 3, -1, -1, -1, 1, 1, 15'h0054, 32'hA5A50054, 32'hA5A50080};
        run_vec(v, 7);

        // Reset during WAIT, then a late ROM ack that must be ignored.
        clear_log();
        rom_en = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 15'h0060;
        repeat (3) step();
        rst = 1'b1;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        chk("arst_rom_stb", int'(rom_stb), 0);
        chk("arst_acks", int'({m0_ack, m0_err, m1_ack, m1_err}), 0);
        chkx("arst_rom_addr", DW'(rom_addr), '0);
        chkx("arst_m0_dat", m0_dat, '0);
        step();
        rst = 1'b0;
        clear_log();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        rom_en = 1'b1;
        repeat (5) step();
        chk("late_ack_m0", m0_ack_at, -1);
        chk("late_ack_m1", m1_ack_at, -1);
        chk("late_ack_stb", stb_cnt, 0);
        v = '{1, 0, 15'h0000, 0, 0, 15'h0000, 1, 3, -1, -1, -1, 1, 1, 15'h0000, 32'hA5A50000, 32'h00000000};
        run_vec(v, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
